// File: rtl/rv_dp.sv
// Multicycle RISC-V datapath: architectural state, holding registers, imm gen, ALU and unified memory port.
// Single-cycle register stages under control-plane strobes; no backpressure, memory read is combinational.
module rv_dp #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] SP_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic        zero,
    input  logic        pcsourse,
    input  logic        pcwrite,
    input  logic        pccen,
    input  logic        irwrite,
    input  logic [1:0]  wbsel,
    input  logic        regwen,
    input  logic [1:0]  immsel,
    input  logic [1:0]  asel,
    input  logic [1:0]  bsel,
    input  logic [3:0]  alusel,
    input  logic        mdrwrite
);

    localparam logic [1:0] WB_PC     = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_MDR    = 2'd2;

    localparam logic [1:0] IMM_L = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;
    localparam logic [1:0] IMM_J = 2'd3;

    localparam logic [1:0] ALUA_REG    = 2'd0;
    localparam logic [1:0] ALUA_PCC    = 2'd1;
    localparam logic [1:0] ALUA_ALUOUT = 2'd2;

    localparam logic [1:0] ALUB_REG = 2'd0;
    localparam logic [1:0] ALUB_IMM = 2'd1;
    localparam logic [1:0] ALUB_ONE = 2'd2;

    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [31:0] pc;
    logic [31:0] pcc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] alu_out;
    logic [31:0] rf [32];

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic [31:0] imm;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;

    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign rd  = ir[11:7];

    assign instr     = ir;
    assign mem_addr  = irwrite ? pc : alu_out;
    assign mem_wdata = b_reg;
    assign zero      = (alu_res == 32'd0);

    always_comb begin
        imm_i = {{20{ir[31]}}, ir[31:20]};
        imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        case (immsel)
            IMM_L:   imm = imm_i;
            IMM_S:   imm = imm_s;
            // JAL reuses the branch-target decode step to form its jump target
            IMM_B:   imm = (ir[6:0] == OP_JAL) ? imm_j : imm_b;
            IMM_J:   imm = imm_j;
            default: imm = 32'd0;
        endcase
    end

    always_comb begin
        case (asel)
            ALUA_REG:    alu_a = a_reg;
            ALUA_PCC:    alu_a = pcc;
            ALUA_ALUOUT: alu_a = alu_out;
            default:     alu_a = 32'd0;
        endcase
        case (bsel)
            ALUB_REG: alu_b = b_reg;
            ALUB_IMM: alu_b = imm;
            ALUB_ONE: alu_b = 32'd1;
            default:  alu_b = 32'd0;
        endcase
    end

    always_comb begin
        case (alusel[3:1])
            3'b000:  alu_res = alusel[0] ? (alu_a - alu_b) : (alu_a + alu_b);
            3'b001:  alu_res = alu_a << alu_b[4:0];
            3'b010:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'b011:  alu_res = {31'd0, alu_a < alu_b};
            3'b100:  alu_res = alu_a ^ alu_b;
            3'b101:  alu_res = alusel[0] ? 32'($signed(alu_a) >>> alu_b[4:0])
                                         : (alu_a >> alu_b[4:0]);
            3'b110:  alu_res = alu_a | alu_b;
            default: alu_res = alu_a & alu_b;
        endcase
    end

    always_comb begin
        case (wbsel)
            WB_PC:     wb_data = pc;
            WB_ALUOUT: wb_data = alu_out;
            WB_MDR:    wb_data = mdr;
            default:   wb_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= RESET_PC;
            pcc <= 32'd0;
            ir  <= 32'd0;
            mdr <= 32'd0;
        end else begin
            if (pcwrite)
                pc <= pcsourse ? alu_out : (pc + 32'd4);
            if (pccen)
                pcc <= pc;
            if (irwrite)
                ir <= mem_rdata;
            if (mdrwrite)
                mdr <= mem_rdata;
        end
    end

    // Free-running holding registers hand results from one control state to the next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            alu_out <= 32'd0;
        end else begin
            a_reg   <= rf[rs1];
            b_reg   <= rf[rs2];
            alu_out <= alu_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                rf[5'(i)] <= (i == 2) ? SP_RESET : 32'd0;
        end else if (regwen && (rd != 5'd0)) begin
            rf[rd] <= wb_data;
        end
    end

endmodule

// File: tb/tb_rv_dp.sv
// Directed plus randomized bench for rv_dp against a behavioural datapath model.
`timescale 1ns/1ps
module tb_rv_dp;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] SP_RST = 32'h0000_7FF0;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic        zero;
    logic        pcsourse;
    logic        pcwrite;
    logic        pccen;
    logic        irwrite;
    logic [1:0]  wbsel;
    logic        regwen;
    logic [1:0]  immsel;
    logic [1:0]  asel;
    logic [1:0]  bsel;
    logic [3:0]  alusel;
    logic        mdrwrite;

    int n_cmp = 0;
    int n_err = 0;

    rv_dp #(.RESET_PC(RST_PC), .SP_RESET(SP_RST)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .instr(instr), .zero(zero),
        .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
        .wbsel(wbsel), .regwen(regwen), .immsel(immsel), .asel(asel), .bsel(bsel),
        .alusel(alusel), .mdrwrite(mdrwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    // Behavioural model of the architectural and holding state
    logic [31:0] m_pc, m_pcc, m_ir, m_mdr, m_a, m_b, m_alu;
    logic [31:0] m_rf [32];

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        logic signed [31:0] t;
        t = v << (32 - bits);
        return t >>> (32 - bits);
    endfunction

    function automatic logic [31:0] m_imm();
        logic [31:0] v;
        case (immsel)
            2'd0: return sx(m_ir >> 20, 12);
            2'd1: return sx(((m_ir >> 25) << 5) | ((m_ir >> 7) & 32'h1F), 12);
            default: begin
                if (immsel == 2'd2 && (m_ir & 32'h7F) != 32'h6F) begin
                    v = (((m_ir >> 31) & 1) << 12) | (((m_ir >> 7) & 1) << 11)
                      | (((m_ir >> 25) & 32'h3F) << 5) | (((m_ir >> 8) & 32'hF) << 1);
                    return sx(v, 13);
                end
                v = (((m_ir >> 31) & 1) << 20) | (((m_ir >> 12) & 32'hFF) << 12)
                  | (((m_ir >> 20) & 1) << 11) | (((m_ir >> 21) & 32'h3FF) << 1);
                return sx(v, 21);
            end
        endcase
    endfunction

    function automatic logic [31:0] m_alu_res();
        logic [31:0] x, y;
        x = (asel == 2'd0) ? m_a : (asel == 2'd1) ? m_pcc : (asel == 2'd2) ? m_alu : 32'd0;
        y = (bsel == 2'd0) ? m_b : (bsel == 2'd1) ? m_imm() : (bsel == 2'd2) ? 32'd1 : 32'd0;
        case (alusel[3:1])
            3'd0: return alusel[0] ? x - y : x + y;
            3'd1: return x << y[4:0];
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return alusel[0] ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_pcc = 0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_alu = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = (i == 2) ? SP_RST : 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] res, wbv, na, nb;
        res = m_alu_res();
        na = m_rf[m_ir[19:15]];
        nb = m_rf[m_ir[24:20]];
        wbv = (wbsel == 2'd0) ? m_pc : (wbsel == 2'd1) ? m_alu : (wbsel == 2'd2) ? m_mdr : 32'd0;
        if (regwen && m_ir[11:7] != 5'd0) m_rf[m_ir[11:7]] = wbv;
        if (pccen) m_pcc = m_pc;
        if (pcwrite) m_pc = pcsourse ? m_alu : m_pc + 32'd4;
        if (irwrite) m_ir = mem_rdata;
        if (mdrwrite) m_mdr = mem_rdata;
        m_a = na; m_b = nb; m_alu = res;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("m_mem_addr", mem_addr, irwrite ? m_pc : m_alu);
        check("m_mem_wdata", mem_wdata, m_b);
        check("m_instr", instr, m_ir);
        check("m_zero", {31'd0, zero}, {31'd0, m_alu_res() == 32'd0});
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        pcsourse = 0; pcwrite = 0; pccen = 0; irwrite = 0; wbsel = 0; regwen = 0;
        immsel = 0; asel = 0; bsel = 0; alusel = 0; mdrwrite = 0; mem_rdata = 0;
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2);
        return {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic load_ir(input logic [31:0] w);
        idle(); irwrite = 1; mem_rdata = w; tick(); idle();
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] val);
        load_ir(enc_i(0, 0, 0, r, 7'h13));
        mdrwrite = 1; mem_rdata = val; tick(); idle();
        wbsel = 2; regwen = 1; tick(); idle();
    endtask

    task automatic expect_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        load_ir(enc_r(r, r, 0));
        tick();
        check(tag, mem_wdata, exp);
    endtask

    task automatic adv_pc(input int n);
        for (int i = 0; i < n; i++) begin
            idle(); pcwrite = 1; tick();
        end
        idle();
    endtask

    initial begin
        idle(); irwrite = 1; rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr", instr, 32'd0);
        check("rst_mem_addr", mem_addr, RST_PC);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        model_reset();
        rst = 0;

        // Fetch of addi x1,x0,5
        idle(); irwrite = 1; pccen = 1; pcwrite = 1; mem_rdata = 32'h0050_0093;
        #1 check("fetch_addr", mem_addr, 32'h0);
        tick();
        check("fetch_instr", instr, 32'h0050_0093);
        idle(); irwrite = 1;
        #1 check("fetch_pc4", mem_addr, 32'h4);
        idle(); asel = 1; bsel = 3;
        #1 check("fetch_pcc0", {31'd0, zero}, 32'd1);
        idle();
        expect_reg("sp_reset", 2, SP_RST);

        // add x3,x1,x2 and write to x0
        write_reg(1, 5);
        write_reg(2, 7);
        load_ir(enc_r(1, 2, 3));
        tick();
        check("add_rs2", mem_wdata, 32'd7);
        tick();
        check("add_aluout", mem_addr, 32'd12);
        wbsel = 1; regwen = 1; tick(); idle();
        expect_reg("add_x3", 3, 32'd12);
        load_ir(enc_r(1, 2, 0));
        tick(); tick();
        wbsel = 1; regwen = 1; tick(); idle();
        expect_reg("x0_hold", 0, 32'd0);

        // beq taken and not taken
        write_reg(5, 9);
        write_reg(6, 9);
        write_reg(7, 8);
        adv_pc(7);
        idle(); irwrite = 1; pccen = 1; pcwrite = 1; mem_rdata = enc_b(32'hFFFF_FFF8, 5, 6); tick();
        idle(); asel = 1; bsel = 1; immsel = 2; tick(); idle();
        check("beq_target", mem_addr, 32'h18);
        alusel = 4'b0001; pcwrite = 1; pcsourse = 1;
        #1 check("beq_zero", {31'd0, zero}, 32'd1);
        tick();
        idle(); irwrite = 1;
        #1 check("beq_pc", mem_addr, 32'h18);
        load_ir(enc_b(32'hFFFF_FFF8, 5, 7));
        tick();
        alusel = 4'b0001; pcsourse = 1;
        #1 check("bnt_zero", {31'd0, zero}, 32'd0);
        tick();
        idle(); irwrite = 1;
        #1 check("bnt_pc_hold", mem_addr, 32'h18);
        idle();

        // JAL
        adv_pc(10);
        idle(); irwrite = 1; pccen = 1; pcwrite = 1; mem_rdata = enc_j(32'h100, 1); tick();
        idle(); asel = 1; bsel = 1; immsel = 2; tick(); idle();
        check("jal_target", mem_addr, 32'h140);
        pcwrite = 1; pcsourse = 1; regwen = 1; wbsel = 0; tick();
        idle(); irwrite = 1;
        #1 check("jal_pc", mem_addr, 32'h140);
        idle();
        expect_reg("jal_link", 1, 32'h44);

        // Load / store
        write_reg(8, 32'h1000);
        load_ir(enc_i(4, 8, 2, 9, 7'h03));
        tick();
        bsel = 1; immsel = 0; tick(); idle();
        check("lw_addr", mem_addr, 32'h1004);
        mdrwrite = 1; mem_rdata = 32'hDEAD_BEEF; tick(); idle();
        wbsel = 2; regwen = 1; tick(); idle();
        expect_reg("lw_data", 9, 32'hDEAD_BEEF);
        load_ir(enc_s(0, 8, 9));
        tick();
        check("sw_data", mem_wdata, 32'hDEAD_BEEF);

        // ALU corners
        write_reg(10, 32'h8000_0000);
        write_reg(11, 32'd4);
        load_ir(enc_r(10, 11, 0));
        tick();
        alusel = 4'b1011; tick(); idle();
        check("sra", mem_addr, 32'hF800_0000);
        write_reg(12, 32'hFFFF_FFFF);
        write_reg(13, 32'd1);
        load_ir(enc_r(12, 13, 0));
        tick();
        alusel = 4'b0100; tick(); idle();
        check("slt", mem_addr, 32'd1);
        alusel = 4'b0110;
        #1 check("sltu_zero", {31'd0, zero}, 32'd1);
        tick(); idle();
        check("sltu", mem_addr, 32'd0);

        // Reset in the middle of a load
        load_ir(enc_i(4, 8, 2, 9, 7'h03));
        tick();
        bsel = 1; tick(); idle();
        mdrwrite = 1; mem_rdata = 32'h1234_5678; tick(); idle();
        #1 rst = 1;
        #1;
        check("mid_rst_instr", instr, 32'd0);
        check("mid_rst_aluout", mem_addr, 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        irwrite = 1;
        #1 check("mid_rst_pc", mem_addr, RST_PC);
        model_reset();
        rst = 0;
        idle();
        load_ir(enc_i(0, 0, 0, 14, 7'h13));
        wbsel = 2; regwen = 1; tick(); idle();
        expect_reg("mid_rst_mdr", 14, 32'd0);
        expect_reg("mid_rst_rf", 9, 32'd0);

        // Randomized control sequences
        for (int i = 0; i < 800; i++) begin
            pcsourse = 1'($urandom);
            pcwrite  = ($urandom_range(0, 3) == 0);
            pccen    = ($urandom_range(0, 3) == 0);
            irwrite  = ($urandom_range(0, 3) == 0);
            wbsel    = 2'($urandom);
            regwen   = ($urandom_range(0, 2) == 0);
            immsel   = 2'($urandom);
            asel     = 2'($urandom);
            bsel     = 2'($urandom);
            alusel   = 4'($urandom);
            mdrwrite = 1'($urandom);
            mem_rdata = $urandom;
            if ($urandom_range(0, 3) == 0) mem_rdata = {mem_rdata[31:7], 7'h6F};
            tick();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv_dp.md
Name: rv_dp

Overview:
- Datapath of the multicycle RISC-V core, directly downstream of the control FSM.
- Consumes the FSM's per-cycle control strobes and returns the current instruction and the ALU zero flag.
- Holds the architectural state (PC, register file) and the multicycle holding registers: PCC, IR, MDR, A, B and ALUOUT.
- Owns the single unified memory port used for both instruction fetch and load/store.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
SP_RESET, 32'h0000_0000, reset value of register x2 (all other registers reset to 0)

Ports:
clk  in  1  clock
rst  in  1  reset
mem_addr  out  32  memory byte address
mem_wdata  out  32  store data
mem_rdata  in  32  memory read data (combinational read, same cycle)
instr  out  32  IR contents
zero  out  1  1 when the combinational ALU result == 0
pcsourse  in  1  0=PC_INC (pc+4), 1=PC_ALU (ALUOUT register)
pcwrite  in  1  PC load enable
pccen  in  1  PCC load enable
irwrite  in  1  IR load enable; also selects the memory address source
wbsel  in  2  0=WB_PC, 1=WB_ALUOUT, 2=WB_MDR, 3=0
regwen  in  1  register file write enable
immsel  in  2  0=IMM_L (I-type), 1=IMM_S, 2=IMM_B, 3=IMM_J
asel  in  2  0=ALUA_REG (A), 1=ALUA_PCC, 2=ALUA_ALUOUT, 3=0
bsel  in  2  0=ALUB_REG (B), 1=ALUB_IMM, 2=ALUB_ONE (32'd1), 3=0
alusel  in  4  {funct3, instr[30]}
mdrwrite  in  1  MDR load enable

Behaviour:
- Reset: clk, asynchronous active-high rst.
  - pc=RESET_PC; pcc, ir, mdr, A, B, ALUOUT = 0.
  - Register file: all 0 except x2=SP_RESET.
  - Resulting outputs: instr=0; mem_addr=RESET_PC; mem_wdata=0.
  - Reset asserted mid-instruction discards all in-flight holding state; the first cycle after release is a fetch from RESET_PC.
- Memory address and store data:
  - mem_addr = irwrite ? pc : ALUOUT.
  - mem_wdata = B.
  - The memory write strobe comes from the control plane, not from this block.
- Fetch-related updates, all at posedge:
  - irwrite: ir <= mem_rdata.
  - pccen: pcc <= pc.
  - pcwrite: pc <= (pcsourse ? ALUOUT : pc+4).
  - pc+4 wraps modulo 2^32.
- MDR: loads mem_rdata when mdrwrite=1, otherwise holds.
- Registers updated every cycle with no enable:
  - A <= rf[ir[19:15]].
  - B <= rf[ir[24:20]].
  - ALUOUT <= combinational ALU result.
  - Consequence: values computed in one FSM state are available in the next.
- Register file:
  - 32x32, two asynchronous read ports, one synchronous write port.
  - Write address rd=ir[11:7]; write is ignored when rd=0, so x0 always reads 0.
  - Write data: WB_PC -> current pc (the pre-update value if pcwrite is high in the same cycle); WB_ALUOUT -> ALUOUT register; WB_MDR -> mdr.
  - A read in the same cycle as a write to the same register returns the old value; A/B capture the new value next cycle.
- Immediate generator, sign-extended to 32 bits:
  - I: ir[31:20].
  - S: {ir[31:25], ir[11:7]}.
  - B: {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - J: {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
  - When ir[6:0]=7'b1101111 (JAL), IMM_B produces the J-type immediate, so the branch-target computation in decode yields the jump target.
- ALU, 32-bit; alusel[3:1] selects the operation:
  - 000: ADD, or SUB when alusel[0]=1.
  - 001: SLL by b[4:0].
  - 010: SLT (signed, result 0/1).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when alusel[0]=1.
  - 110: OR.
  - 111: AND.
  - alusel[0] is ignored for all other ops. Overflow wraps.
- zero is combinational from the current ALU result, not from ALUOUT.

Test Plan:
- Reset release with RESET_PC=0, mem[0]=32'h00500093 (addi x1,x0,5) -> mem_addr=0 first cycle; after fetch edge: instr=32'h00500093, pc=4, pcc=0.
- Drive add sequence with x1=5, x2=7, asel=0, bsel=0, alusel=0000, then wbsel=1, regwen=1, rd=3 -> x3=12; same with rd=0 -> x0 still reads 0.
- Decode of beq with imm=-8 at pcc=0x20 (asel=1, bsel=1, immsel=2) -> ALUOUT=0x18. Next cycle A=B=9, alusel=0001: zero=1; pcwrite=1, pcsourse=1 -> pc=0x18. With A=9, B=8: zero=0 and pc holds when pcwrite=0.
- JAL with imm=+0x100 at pcc=0x40, pc=0x44: decode -> ALUOUT=0x140. Exec with pcwrite, pcsourse=1, regwen, wbsel=0, rd=1 -> x1=0x44, pc=0x140.
- Load/store: rs1=0x1000, imm=4, immsel=0 -> mem_addr=0x1004 in the next state. mdrwrite with mem_rdata=0xDEADBEEF then wbsel=2 -> rd=0xDEADBEEF. Store path: mem_wdata equals the rs2 value.
- ALU corners: SRA 0x80000000 by 4 -> 0xF8000000; SLT -1<1 -> 1, SLTU -> 0; rst asserted mid-LW -> pc=RESET_PC, mdr=0 immediately.
